fib_engine: RTL and testbench

Parametrised iterative Fibonacci-recurrence engine: successor of the fixed 32-bit `main` fib core driven by the top-level bench. Loads a seed pair and an iteration count on a start pulse and advances the recurrence one step per clock. Reports `b` after `n` steps with a one-cycle completion pulse. Adds configurable width, wrap/saturate/modulo arithmetic, sticky overflow, input-error detection, a busy indicator, and synchronous reset.

---
 rtl/fib_pkg.sv | 18 +
 rtl/fib_step.sv | 36 +++
 rtl/fib_engine.sv | 138 +++++++++++++
 tb/tb_fib_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types for the Fibonacci recurrence engine and its step datapath.
package fib_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_MOD  = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_step.sv
// One recurrence step: a_next = op(a + b) with wrap, saturate or modulo reduction.
module fib_step
  import fib_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  mode_t        mode_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] a_next_o,
  output logic         ovf_o
);

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i};
    a_next_o = sum[W-1:0];
    ovf_o    = 1'b0;
    case (mode_i)
      MODE_SAT: begin
        if (sum[W]) begin
          a_next_o = '1;
          ovf_o    = 1'b1;
        end
      end
      // Operands are already below m, so a single subtraction fully reduces the sum.
      MODE_MOD: begin
        if (sum >= {1'b0, m_i}) a_next_o = W'(sum - {1'b0, m_i});
      end
      default: ovf_o = sum[W];
    endcase
  end

endmodule

// File: rtl/fib_engine.sv
// Iterative Fibonacci-recurrence engine: loads seeds on a start, steps once per clock,
// and pulses w_enable with the final b.
module fib_engine
  import fib_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_enable,
  input  logic [NW-1:0] init_n,
  input  logic [W-1:0]  init_a,
  input  logic [W-1:0]  init_b,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  modulus,
  output logic          w_enable,
  output logic [W-1:0]  result,
  output logic          busy,
  output logic          overflow,
  output logic          error
);

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [NW-1:0] cnt_q, cnt_d;
  mode_t         mode_q, mode_d;
  logic          wen_q, wen_d, busy_q, busy_d, ovf_q, ovf_d, err_q, err_d;

  logic [W-1:0]  step_a;
  logic          step_ovf;
  mode_t         mode_in;
  logic          reject;

  fib_step #(.W(W)) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .mode_i   (mode_q),
    .m_i      (m_q),
    .a_next_o (step_a),
    .ovf_o    (step_ovf)
  );

  // Reserved encoding 3 behaves as WRAP.
  assign mode_in = (mode == 2'd3) ? MODE_WRAP : mode_t'(mode);
  assign reject  = (mode_in == MODE_MOD) &&
                   ((modulus == '0) || (init_a >= modulus) || (init_b >= modulus));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    wen_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        a_d   = step_a;
        b_d   = a_q;
        cnt_d = cnt_q - NW'(1);
        ovf_d = ovf_q | step_ovf;
        if (cnt_q == NW'(1)) begin
          state_d  = ST_DONE;
          wen_d    = 1'b1;
          result_d = a_q;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (r_enable) begin
          a_d    = init_a;
          b_d    = init_b;
          m_d    = modulus;
          mode_d = mode_in;
          cnt_d  = init_n;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
          if (reject) begin
            state_d  = ST_DONE;
            err_d    = 1'b1;
            b_d      = '0;
            wen_d    = 1'b1;
            result_d = '0;
          end else if (init_n == '0) begin
            state_d  = ST_DONE;
            wen_d    = 1'b1;
            result_d = init_b;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_WRAP;
      result_q <= '0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign w_enable = wen_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_fib_engine.sv
// Directed scoreboard bench for fib_engine: expected results are queued at each start
// and compared when w_enable fires.
module tb_fib_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_enable;
  logic [31:0] init_n, init_a, init_b, modulus;
  logic [1:0]  mode;
  logic        w_enable, busy, overflow, error;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fib_engine #(.W(32), .NW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .r_enable (r_enable),
    .init_n   (init_n),
    .init_a   (init_a),
    .init_b   (init_b),
    .mode     (mode),
    .modulus  (modulus),
    .w_enable (w_enable),
    .result   (result),
    .busy     (busy),
    .overflow (overflow),
    .error    (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] md, input logic [31:0] m);
    exp_t        e;
    logic [32:0] s;
    logic [31:0] ca, cb, na;
    e.ovf = 1'b0;
    e.err = 1'b0;
    e.lat = int'(n) + 1;
    if (md == 2'd2 && (m == 0 || a >= m || b >= m)) begin
      e.res = 32'd0;
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    ca = a;
    cb = b;
    for (int i = 0; i < int'(n); i++) begin
      s = {1'b0, ca} + {1'b0, cb};
      if (md == 2'd1) begin
        na = s[32] ? 32'hFFFF_FFFF : s[31:0];
        if (s[32]) e.ovf = 1'b1;
      end else if (md == 2'd2) begin
        na = (s >= {1'b0, m}) ? 32'(s - {1'b0, m}) : s[31:0];
      end else begin
        na = s[31:0];
        if (s[32]) e.ovf = 1'b1;
      end
      cb = ca;
      ca = na;
    end
    e.res = cb;
    return e;
  endfunction

  // Called #1 after a rising edge; the following edge is the accepting edge.
  task automatic start(input logic [31:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] md, input logic [31:0] m);
    init_n   = n;
    init_a   = a;
    init_b   = b;
    mode     = md;
    modulus  = m;
    r_enable = 1'b1;
    sb.push_back(model(n, a, b, md, m));
    @(posedge clk);
    #1;
    r_enable = 1'b0;
    init_n   = 32'($urandom_range(1, 3));
    init_a   = $urandom;
    init_b   = $urandom;
    modulus  = $urandom;
    mode     = 2'($urandom);
  endtask

  task automatic wait_result(input string tag, input int pulse_at);
    int   cyc     = 1;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (w_enable !== 1'b1 && cyc < 2000) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == pulse_at) begin
        r_enable = 1'b1;
        init_n   = 32'd1;
        init_a   = 32'd99;
      end
      @(posedge clk);
      #1;
      r_enable = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, ".wen"}, 64'(w_enable), 64'd1);
    check({tag, ".lat"}, 64'(cyc), 64'(e.lat));
    check({tag, ".res"}, 64'(result), 64'(e.res));
    check({tag, ".ovf"}, 64'(overflow), 64'(e.ovf));
    check({tag, ".err"}, 64'(error), 64'(e.err));
    check({tag, ".busy"}, {62'd0, busy_ok, busy}, 64'b10);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst      = 1'b1;
    r_enable = 1'b0;
    init_n   = '0;
    init_a   = '0;
    init_b   = '0;
    mode     = '0;
    modulus  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.wen",  64'(w_enable), 64'd0);
    check("rst.busy", 64'(busy),     64'd0);
    check("rst.res",  64'(result),   64'd0);
    check("rst.ovf",  64'(overflow), 64'd0);
    check("rst.err",  64'(error),    64'd0);
    rst = 1'b0;
    idle_cycle();

    start(32'd40, 32'd1, 32'd0, 2'd0, 32'd0);
    wait_result("wrap40", 0);
    idle_cycle();
    check("hold.wen", 64'(w_enable), 64'd0);
    check("hold.res", 64'(result),   64'd102334155);

    start(32'd48, 32'd1, 32'd0, 2'd0, 32'd0);
    wait_result("wrap48", 0);
    check("wrap48.const", 64'(result), 64'd512559680);
    idle_cycle();
    start(32'd48, 32'd1, 32'd0, 2'd1, 32'd0);
    wait_result("sat48", 0);
    check("sat48.const", 64'(result), 64'hFFFF_FFFF);
    idle_cycle();
    start(32'd48, 32'd1, 32'd0, 2'd3, 32'd0);
    wait_result("rsvd48", 0);
    idle_cycle();
    start(32'd40, 32'd1, 32'd0, 2'd2, 32'd10);
    wait_result("mod40", 0);
    check("mod40.const", 64'(result), 64'd5);
    idle_cycle();
    start(32'd40, 32'd12, 32'd0, 2'd2, 32'd10);
    wait_result("modrej", 0);
    idle_cycle();
    check("modrej.hold", 64'(error), 64'd1);
    start(32'd0, 32'd1, 32'd7, 2'd0, 32'd0);
    wait_result("n0", 0);
    check("n0.const", 64'(result), 64'd7);
    idle_cycle();

    // Back-to-back: second start issued in the DONE cycle; pulse during RUN ignored.
    start(32'd5, 32'd1, 32'd0, 2'd0, 32'd0);
    wait_result("b2b5", 0);
    start(32'd6, 32'd1, 32'd0, 2'd0, 32'd0);
    wait_result("b2b6", 3);
    check("b2b6.const", 64'(result), 64'd8);

    // Reset mid-run with a simultaneous start request.
    idle_cycle();
    start(32'd40, 32'd1, 32'd0, 2'd0, 32'd0);
    repeat (10) idle_cycle();
    rst      = 1'b1;
    r_enable = 1'b1;
    init_n   = 32'd3;
    idle_cycle();
    rst      = 1'b0;
    r_enable = 1'b0;
    check("midrst.wen",  64'(w_enable), 64'd0);
    check("midrst.busy", 64'(busy),     64'd0);
    check("midrst.res",  64'(result),   64'd0);
    check("midrst.ovf",  64'(overflow), 64'd0);
    check("midrst.err",  64'(error),    64'd0);
    void'(sb.pop_back());
    seen = 1'b0;
    repeat (45) begin
      idle_cycle();
      if (w_enable !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("midrst.quiet", 64'(seen), 64'd0);

    start(32'd10, 32'd1, 32'd0, 2'd0, 32'd0);
    wait_result("after_rst10", 0);
    check("after_rst10.const", 64'(result), 64'd55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
